// File: rtl/ddr_cmd_sequencer.sv
// Closed-page DDR4 command scheduler: ACT -> tRCD -> CAS -> CL/CWL -> burst -> PRE -> tRP,
// one transaction at a time, with periodic refresh taking priority over new requests.
module ddr_cmd_sequencer #(
    parameter int T_RCD  = 16,
    parameter int T_RP   = 16,
    parameter int T_RFC  = 313,
    parameter int T_REFI = 7800,
    parameter int CNT_W  = 16
) (
    input  logic       clock_t,
    input  logic       reset_n,
    input  logic       init_done,
    input  logic       req_valid,
    input  logic [1:0] req_rw,
    output logic       req_ready,
    input  logic [7:0] RD_DELAY,
    input  logic [7:0] WR_DELAY,
    input  logic [3:0] BL,
    output logic       act_rdy,
    output logic       cas_rdy,
    output logic       rw_rdy,
    output logic       pre_rdy,
    output logic       refresh_rdy,
    output logic       ref_pending,
    output logic       busy
);

    localparam logic [3:0] S_IDLE  = 4'd0;
    localparam logic [3:0] S_ACT   = 4'd1;
    localparam logic [3:0] S_TRCD  = 4'd2;
    localparam logic [3:0] S_CAS   = 4'd3;
    localparam logic [3:0] S_CLAT  = 4'd4;
    localparam logic [3:0] S_BURST = 4'd5;
    localparam logic [3:0] S_PRE   = 4'd6;
    localparam logic [3:0] S_TRP   = 4'd7;
    localparam logic [3:0] S_REF   = 4'd8;
    localparam logic [3:0] S_TRFC  = 4'd9;

    localparam logic [1:0] RW_NOP   = 2'b00;
    localparam logic [1:0] RW_WRITE = 2'b10;

    localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);
    localparam logic [CNT_W-1:0] RCD_WAIT  = CNT_W'(T_RCD - 1);
    localparam logic [CNT_W-1:0] RP_WAIT   = CNT_W'(T_RP - 1);
    localparam logic [CNT_W-1:0] RFC_WAIT  = CNT_W'(T_RFC - 1);
    localparam logic [CNT_W-1:0] REFI_LOAD = CNT_W'(T_REFI);
    localparam logic [CNT_W-1:0] BURST_BL8 = CNT_W'(4);
    localparam logic [CNT_W-1:0] BURST_BL4 = CNT_W'(2);

    logic [3:0]       state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic [CNT_W-1:0] ref_cnt;
    logic [7:0]       lat_delay;
    logic             lat_long;
    logic             accept;
    logic             ref_expire;
    logic             ref_pending_next;
    logic [7:0]       sel_delay;
    logic [CNT_W-1:0] burst_len;

    assign sel_delay        = (req_rw == RW_WRITE) ? WR_DELAY : RD_DELAY;
    assign burst_len        = lat_long ? BURST_BL8 : BURST_BL4;
    assign ref_expire       = init_done && (ref_cnt == ONE);
    // An expiry landing on the REF-issue edge must win, otherwise that refresh is lost.
    assign ref_pending_next = ref_expire || (ref_pending && (state_next != S_REF));

    // Wait states count the cycles remaining including the current one; a zero-length
    // wait skips the wait state entirely.
    always_comb begin
        // NOTE: defaults first so every path assigns every output -- no latches.
        state_next = state;
        cnt_next   = cnt;
        accept     = 1'b0;
        case (state)
            S_IDLE: begin
                if (ref_pending) begin
                    state_next = S_REF;
                end else if (req_valid && req_ready) begin
                    accept = 1'b1;
                    if (req_rw != RW_NOP) state_next = S_ACT;
                end
            end
            S_ACT: begin
                if (T_RCD == 1) begin
                    state_next = S_CAS;
                end else begin
                    state_next = S_TRCD;
                    cnt_next   = RCD_WAIT;
                end
            end
            S_TRCD: begin
                if (cnt == ONE) state_next = S_CAS;
                else            cnt_next   = cnt - ONE;
            end
            S_CAS: begin
                if (lat_delay == 8'd1) begin
                    state_next = S_BURST;
                    cnt_next   = burst_len;
                end else begin
                    state_next = S_CLAT;
                    cnt_next   = CNT_W'(lat_delay - 8'd1);
                end
            end
            S_CLAT: begin
                if (cnt == ONE) begin
                    state_next = S_BURST;
                    cnt_next   = burst_len;
                end else begin
                    cnt_next = cnt - ONE;
                end
            end
            S_BURST: begin
                if (cnt == ONE) state_next = S_PRE;
                else            cnt_next   = cnt - ONE;
            end
            S_PRE: begin
                if (T_RP == 1) begin
                    state_next = S_IDLE;
                end else begin
                    state_next = S_TRP;
                    cnt_next   = RP_WAIT;
                end
            end
            S_TRP: begin
                if (cnt == ONE) state_next = S_IDLE;
                else            cnt_next   = cnt - ONE;
            end
            S_REF: begin
                if (T_RFC == 1) begin
                    state_next = S_IDLE;
                end else begin
                    state_next = S_TRFC;
                    cnt_next   = RFC_WAIT;
                end
            end
            S_TRFC: begin
                if (cnt == ONE) state_next = S_IDLE;
                else            cnt_next   = cnt - ONE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state and registered, so each strobe is high
    // for exactly the cycle the FSM spends in the matching state.
    always_ff @(posedge clock_t or negedge reset_n) begin
        if (!reset_n) begin
            state       <= S_IDLE;
            cnt         <= '0;
            ref_cnt     <= REFI_LOAD;
            ref_pending <= 1'b0;
            lat_delay   <= 8'd1;
            lat_long    <= 1'b0;
            req_ready   <= 1'b0;
            act_rdy     <= 1'b0;
            cas_rdy     <= 1'b0;
            rw_rdy      <= 1'b0;
            pre_rdy     <= 1'b0;
            refresh_rdy <= 1'b0;
            busy        <= 1'b0;
        end else begin
            // NOTE: non-blocking for all state so every register sees pre-edge values.
            state       <= state_next;
            cnt         <= cnt_next;
            ref_pending <= ref_pending_next;
            if (init_done) ref_cnt <= ref_expire ? REFI_LOAD : (ref_cnt - ONE);
            if (accept) begin
                lat_delay <= (sel_delay == 8'd0) ? 8'd1 : sel_delay;
                lat_long  <= (BL != 4'd4);
            end
            req_ready   <= (state_next == S_IDLE) && init_done && !ref_pending_next;
            act_rdy     <= (state_next == S_ACT);
            cas_rdy     <= (state_next == S_CAS);
            rw_rdy      <= (state_next == S_BURST);
            pre_rdy     <= (state_next == S_PRE);
            refresh_rdy <= (state_next == S_REF);
            busy        <= (state_next != S_IDLE);
        end
    end

endmodule

// File: tb/tb_ddr_cmd_sequencer.sv
// Scoreboard bench for ddr_cmd_sequencer: expected strobe events (cycle + strobe vector)
// are queued at accept time and matched by a negedge monitor as the DUT emits them.
module tb_ddr_cmd_sequencer;

    localparam int T_RCD  = 4;
    localparam int T_RP   = 3;
    localparam int T_RFC  = 6;
    localparam int T_REFI = 50;

    localparam logic [4:0] EV_ACT = 5'b10000;
    localparam logic [4:0] EV_CAS = 5'b01000;
    localparam logic [4:0] EV_RW  = 5'b00100;
    localparam logic [4:0] EV_PRE = 5'b00010;
    localparam logic [4:0] EV_REF = 5'b00001;

    logic       clock_t = 1'b0;
    logic       reset_n = 1'b1;
    logic       init_done = 1'b0;
    logic       req_valid = 1'b0;
    logic [1:0] req_rw = 2'b00;
    logic       req_ready;
    logic [7:0] RD_DELAY = 8'd1;
    logic [7:0] WR_DELAY = 8'd1;
    logic [3:0] BL = 4'd4;
    logic       act_rdy, cas_rdy, rw_rdy, pre_rdy, refresh_rdy, ref_pending, busy;

    typedef struct {
        int         cyc;
        logic [4:0] vec;
    } ev_t;

    ev_t        sb[$];
    ev_t        mon_e;
    logic [4:0] mon_v;
    int         cyc = 0;
    int         rel0 = 0;
    int         tests = 0;
    int         errors = 0;
    bit         mon_en = 1'b0;

    ddr_cmd_sequencer #(
        .T_RCD(T_RCD), .T_RP(T_RP), .T_RFC(T_RFC), .T_REFI(T_REFI), .CNT_W(16)
    ) dut (
        .clock_t(clock_t), .reset_n(reset_n), .init_done(init_done),
        .req_valid(req_valid), .req_rw(req_rw), .req_ready(req_ready),
        .RD_DELAY(RD_DELAY), .WR_DELAY(WR_DELAY), .BL(BL),
        .act_rdy(act_rdy), .cas_rdy(cas_rdy), .rw_rdy(rw_rdy), .pre_rdy(pre_rdy),
        .refresh_rdy(refresh_rdy), .ref_pending(ref_pending), .busy(busy)
    );

    always #5 clock_t = ~clock_t;
    always @(posedge clock_t) cyc <= cyc + 1;

    // Every strobe cycle must match the head of the scoreboard exactly.
    always @(negedge clock_t) begin
        if (mon_en) begin
            mon_v = {act_rdy, cas_rdy, rw_rdy, pre_rdy, refresh_rdy};
            if (mon_v !== 5'b0) begin
                tests++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL strobe_unexpected: cycle %0d got strobes %b, expected none", cyc, mon_v);
                end else begin
                    mon_e = sb.pop_front();
                    if (mon_e.cyc !== cyc || mon_e.vec !== mon_v) begin
                        errors++;
                        $display("FAIL strobe_seq: got %b at cycle %0d, expected %b at cycle %0d",
                                 mon_v, cyc, mon_e.vec, mon_e.cyc);
                    end
                end
            end
        end
    end

    function automatic void push_ev(input int c, input logic [4:0] v);
        ev_t e;
        e.cyc = c;
        e.vec = v;
        sb.push_back(e);
    endfunction

    // Expected timeline of one accepted transaction; returns the pre_rdy cycle.
    function automatic int push_txn(input int n, input logic [1:0] rw, input int rd, input int wr,
                                    input int bl);
        int c, d, len;
        if (rw == 2'b00) return n;
        c   = n + 1 + T_RCD;
        d   = (rw == 2'b10) ? wr : rd;
        if (d == 0) d = 1;
        len = (bl == 4) ? 2 : 4;
        push_ev(n + 1, EV_ACT);
        push_ev(c, EV_CAS);
        for (int i = 0; i < len; i++) push_ev(c + d + i, EV_RW);
        push_ev(c + d + len, EV_PRE);
        return c + d + len;
    endfunction

    task automatic apply_reset(input logic init);
        @(negedge clock_t);
        reset_n   = 1'b0;
        req_valid = 1'b0;
        init_done = init;
        mon_en    = 1'b1;
        repeat (2) @(negedge clock_t);
        sb.delete();
        reset_n = 1'b1;
        rel0    = cyc;
    endtask

    // Called at a negedge; holds the request until accepted, then scrambles the delay inputs.
    task automatic issue(input logic [1:0] rw, input int rd, input int wr, input int bl,
                         output int n, output int last);
        int waited;
        req_valid = 1'b1;
        req_rw    = rw;
        RD_DELAY  = 8'(rd);
        WR_DELAY  = 8'(wr);
        BL        = 4'(bl);
        waited    = 0;
        while (!req_ready && waited < 400) begin
            @(negedge clock_t);
            waited++;
        end
        n = cyc;
        if (!req_ready) begin
            tests++;
            errors++;
            $display("FAIL accept_timeout: req_ready still %b after %0d cycles, required 1", req_ready, waited);
            last      = n;
            req_valid = 1'b0;
            return;
        end
        last = push_txn(n, rw, rd, wr, bl);
        @(negedge clock_t);
        req_valid = 1'b0;
        req_rw    = 2'b01;
        RD_DELAY  = 8'd1;
        WR_DELAY  = 8'd1;
        BL        = 4'd4;
    endtask

    task automatic wait_done(input int last);
        while (cyc < last + 3) @(negedge clock_t);
        tests++;
        if (sb.size() !== 0) begin
            errors++;
            $display("FAIL strobes_missing: %0d expected strobes not seen (first due cycle %0d), required 0",
                     sb.size(), sb[0].cyc);
        end
    endtask

    task automatic test_reset;
        @(negedge clock_t);
        reset_n = 1'b0;
        init_done = 1'b1;
        #1;
        tests++;
        if ({req_ready, act_rdy, cas_rdy, rw_rdy, pre_rdy, refresh_rdy, ref_pending, busy} !== 8'b0) begin
            errors++;
            $display("FAIL reset_outputs: got %b, required 00000000",
                     {req_ready, act_rdy, cas_rdy, rw_rdy, pre_rdy, refresh_rdy, ref_pending, busy});
        end
        apply_reset(1'b1);
        @(negedge clock_t);
        tests++;
        if (req_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle_ready: req_ready=%b busy=%b, required 1 0", req_ready, busy);
        end
    endtask

    task automatic test_read;
        int n, last;
        apply_reset(1'b1);
        issue(2'b01, 10, 3, 8, n, last);
        tests++;
        if (last !== n + 19) begin
            errors++;
            $display("FAIL read_model: pre cycle %0d, required %0d", last, n + 19);
        end
        while (cyc < last + T_RP - 1) @(negedge clock_t);
        tests++;
        if (req_ready !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL read_trp_hold: req_ready=%b busy=%b, required 0 1", req_ready, busy);
        end
        @(negedge clock_t);
        tests++;
        if (req_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL read_trp_done: req_ready=%b busy=%b, required 1 0", req_ready, busy);
        end
        wait_done(last);
    endtask

    task automatic test_write_zero_delay;
        int n, last;
        apply_reset(1'b1);
        issue(2'b10, 9, 0, 4, n, last);
        wait_done(last);
    endtask

    task automatic test_nop;
        int n, last;
        apply_reset(1'b1);
        issue(2'b00, 5, 5, 8, n, last);
        tests++;
        if (req_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL nop_ready: req_ready=%b busy=%b, required 1 0", req_ready, busy);
        end
        wait_done(n + 10);
    endtask

    task automatic test_back_to_back;
        int n1, last1, n2, last2;
        apply_reset(1'b1);
        issue(2'b01, 3, 0, 4, n1, last1);
        issue(2'b01, 3, 0, 4, n2, last2);
        tests++;
        if (n2 !== last1 + T_RP) begin
            errors++;
            $display("FAIL b2b_gap: second accept at cycle %0d, required %0d", n2, last1 + T_RP);
        end
        wait_done(last2);
    endtask

    task automatic test_refresh;
        int r0, n, last, waited;
        apply_reset(1'b1);
        waited = 0;
        while (!ref_pending && waited < 2 * T_REFI) begin
            @(negedge clock_t);
            waited++;
        end
        r0 = cyc;
        tests++;
        if (r0 !== rel0 + T_REFI) begin
            errors++;
            $display("FAIL refresh_due: ref_pending at cycle %0d, required %0d", r0, rel0 + T_REFI);
        end
        push_ev(r0 + 1, EV_REF);
        req_valid = 1'b1;
        req_rw    = 2'b01;
        @(negedge clock_t);
        tests++;
        if (ref_pending !== 1'b0 || req_ready !== 1'b0) begin
            errors++;
            $display("FAIL refresh_issue: ref_pending=%b req_ready=%b, required 0 0", ref_pending, req_ready);
        end
        issue(2'b01, 2, 0, 4, n, last);
        tests++;
        if (n !== r0 + 1 + T_RFC) begin
            errors++;
            $display("FAIL refresh_block: accept at cycle %0d, required %0d", n, r0 + 1 + T_RFC);
        end
        wait_done(last);
    endtask

    task automatic test_refresh_no_accumulate;
        int n, last, ref1, ref2, e;
        apply_reset(1'b1);
        issue(2'b01, 120, 0, 8, n, last);
        ref1 = last + T_RP + 1;
        e = rel0 + T_REFI;
        while (e < ref1) e += T_REFI;
        ref2 = ((e > ref1 + T_RFC) ? e : ref1 + T_RFC) + 1;
        push_ev(ref1, EV_REF);
        push_ev(ref2, EV_REF);
        while (cyc < last) @(negedge clock_t);
        tests++;
        if (ref_pending !== 1'b1) begin
            errors++;
            $display("FAIL refresh_waits: ref_pending=%b during transaction, required 1", ref_pending);
        end
        wait_done(ref2);
    endtask

    task automatic test_reset_mid_burst;
        int n, last;
        apply_reset(1'b1);
        issue(2'b01, 2, 0, 8, n, last);
        while (cyc < n + 1 + T_RCD + 3) @(negedge clock_t);
        #2;
        reset_n = 1'b0;
        #1;
        tests++;
        if (rw_rdy !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_burst: rw_rdy=%b busy=%b, required 0 0", rw_rdy, busy);
        end
        sb.delete();
        repeat (2) @(negedge clock_t);
        reset_n = 1'b1;
        repeat (12) @(negedge clock_t);
        tests++;
        if (busy !== 1'b0 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release: busy=%b req_ready=%b, required 0 1", busy, req_ready);
        end
    endtask

    task automatic test_init_done;
        int n, last, ready_cnt, pend_cnt;
        apply_reset(1'b0);
        req_valid = 1'b1;
        req_rw    = 2'b01;
        ready_cnt = 0;
        pend_cnt  = 0;
        for (int i = 0; i < T_REFI + 10; i++) begin
            @(negedge clock_t);
            if (req_ready) ready_cnt++;
            if (ref_pending) pend_cnt++;
        end
        tests++;
        if (ready_cnt !== 0 || pend_cnt !== 0) begin
            errors++;
            $display("FAIL init_gate: ready cycles %0d pending cycles %0d, required 0 0", ready_cnt, pend_cnt);
        end
        init_done = 1'b1;
        issue(2'b01, 2, 0, 4, n, last);
        init_done = 1'b0;
        req_valid = 1'b1;
        while (cyc < last + T_RP + 5) @(negedge clock_t);
        tests++;
        if (req_ready !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL init_drop: req_ready=%b busy=%b, required 0 0", req_ready, busy);
        end
        req_valid = 1'b0;
        wait_done(last);
    endtask

    initial begin
        test_reset();
        test_read();
        test_write_zero_delay();
        test_nop();
        test_back_to_back();
        test_refresh();
        test_refresh_no_accumulate();
        test_reset_mid_burst();
        test_init_done();
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, tests run %0d", tests);
        $fatal(1, "watchdog");
    end

endmodule
